uart_tx_arbiter: RTL

//  Shares the single SoC UART transmitter (drives uart_tx via the UART TX core)

---
 rtl/uart_tx_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter : round-robin, packet-locking share of one UART TX byte port
// Revision 1.0
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int DATA_W       = 8,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 64,
  localparam int GW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tx_valid,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_ready,
  output logic [GW-1:0]               grant_id,
  output logic                        busy
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state, state_n;
  logic [GW-1:0]     grant_id_n;
  logic [GW-1:0]     rr_ptr, rr_ptr_n;
  logic [GW-1:0]     pick;
  logic              found;
  logic [BW-1:0]     burst_cnt, burst_cnt_n;
  logic [IW-1:0]     idle_cnt, idle_cnt_n;
  logic              busy_n;
  logic              owner_valid;
  logic              xfer;
  logic              release_now;
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  assign owner_valid = req_valid[grant_id];
  assign xfer        = (state == GRANT) && owner_valid && tx_ready;

  // Scan from the farthest offset inward so the nearest requester after rr_ptr wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        pick  = GW'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_n     = state;
    grant_id_n  = grant_id;
    rr_ptr_n    = rr_ptr;
    burst_cnt_n = burst_cnt;
    idle_cnt_n  = idle_cnt;
    busy_n      = busy;
    release_now = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n     = GRANT;
          grant_id_n  = pick;
          busy_n      = 1'b1;
          burst_cnt_n = '0;
          idle_cnt_n  = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
          idle_cnt_n = '0;
          if (burst_cnt != BW'(MAX_BURST)) burst_cnt_n = burst_cnt + 1'b1;
          if (req_last[grant_id] || (burst_cnt == BW'(MAX_BURST - 1))) release_now = 1'b1;
        end else if (owner_valid) begin
          // Backpressure stall: owner is still active, never a timeout.
          idle_cnt_n = '0;
        end else begin
          if (idle_cnt != IW'(IDLE_TIMEOUT)) idle_cnt_n = idle_cnt + 1'b1;
          if (idle_cnt == IW'(IDLE_TIMEOUT - 1)) release_now = 1'b1;
        end
        if (release_now) begin
          state_n     = IDLE;
          rr_ptr_n    = grant_id;
          burst_cnt_n = '0;
          idle_cnt_n  = '0;
          busy_n      = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    if (state == GRANT) begin
      tx_valid            = owner_valid;
      tx_data             = data_arr[grant_id];
      req_ready[grant_id] = tx_ready;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_id  <= '0;
      rr_ptr    <= GW'(NUM_REQ - 1);
      burst_cnt <= '0;
      idle_cnt  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      grant_id  <= grant_id_n;
      rr_ptr    <= rr_ptr_n;
      burst_cnt <= burst_cnt_n;
      idle_cnt  <= idle_cnt_n;
      busy      <= busy_n;
    end
  end

endmodule
`default_nettype wire
